// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative CORDIC in vectoring mode, one micro-rotation per clock.
// Converts a Cartesian vector (x,y) into a binary angle atan2(y,x) and a gain-corrected magnitude.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | in_ready high, waiting for a vector
// ITER   | one micro-rotation per clock, cnt = current iteration index
// SCALE  | multiply X by 1/K, register angle and magnitude
// OUT    | out_valid held with stable results until out_ready
module cordic_vectoring #(
  parameter int ITERATIONS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] angle_out,
  output logic [31:0] mag_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ITER  = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [4:0]  LAST_CNT = 5'(ITERATIONS - 1);
  localparam logic [31:0] INV_GAIN = 32'd1304065748;
  localparam logic [31:0] ANGLE_PI = 32'h8000_0000;

  // round(atan(2^-i) * 2^31 / pi): binary angle where 2^32 is a full turn
  localparam logic [31:0] ATAN [32] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };

  logic [1:0]         state;
  logic [4:0]         cnt;
  logic signed [33:0] x_q;
  logic signed [33:0] y_q;
  logic [31:0]        z_q;
  logic               zero_q;

  logic signed [33:0] x_ext;
  logic signed [33:0] y_ext;
  logic signed [33:0] x_sh;
  logic signed [33:0] y_sh;
  logic [65:0]        prod;
  logic [31:0]        mag_next;

  assign x_ext = {{2{x_in[31]}}, x_in};
  assign y_ext = {{2{y_in[31]}}, y_in};
  assign x_sh  = x_q >>> cnt;
  assign y_sh  = y_q >>> cnt;

  // X is never negative after pre-rotation, so an unsigned product is exact
  assign prod     = {32'd0, x_q} * {34'd0, INV_GAIN};
  assign mag_next = 32'(prod >> 31);

  assign in_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      zero_q    <= 1'b0;
      out_valid <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            zero_q <= (x_in == 32'd0) && (y_in == 32'd0);
            cnt    <= '0;
            // Left half-plane: rotate by pi so the iterations only see |angle| <= pi/2
            if (x_in[31]) begin
              x_q <= -x_ext;
              y_q <= -y_ext;
              z_q <= ANGLE_PI;
            end else begin
              x_q <= x_ext;
              y_q <= y_ext;
              z_q <= '0;
            end
            state <= S_ITER;
          end
        end
        S_ITER: begin
          if (y_q[33]) begin
            x_q <= x_q - y_sh;
            y_q <= y_q + x_sh;
            z_q <= z_q - ATAN[cnt];
          end else begin
            x_q <= x_q + y_sh;
            y_q <= y_q - x_sh;
            z_q <= z_q + ATAN[cnt];
          end
          cnt <= cnt + 5'd1;
          if (cnt == LAST_CNT) begin
            state <= S_SCALE;
          end
        end
        S_SCALE: begin
          angle_out <= zero_q ? 32'd0 : z_q;
          mag_out   <= zero_q ? 32'd0 : mag_next;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Bench for cordic_vectoring: two instances (30 and 8 iterations) behind a selector,
// scoreboard of real atan2/hypot expectations pushed on accept and popped on output.
module tb_cordic_vectoring;

  localparam real PI          = 3.14159265358979323846;
  localparam real LSB_PER_RAD = 2147483648.0 / PI;

  typedef struct {
    logic [31:0] ang;
    real         mag;
    real         ang_tol;
    real         mag_tol;
    bit          zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] x_in = '0;
  logic [31:0] y_in = '0;
  logic        sel8 = 1'b0;

  logic        rdy_a, ov_a, rdy_b, ov_b;
  logic [31:0] ang_a, mag_a, ang_b, mag_b;
  logic        in_ready, out_valid;
  logic [31:0] angle_out, mag_out;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  cordic_vectoring #(.ITERATIONS(30)) dut30 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel8), .in_ready(rdy_a),
    .x_in(x_in), .y_in(y_in), .out_valid(ov_a), .out_ready(out_ready),
    .angle_out(ang_a), .mag_out(mag_a)
  );

  cordic_vectoring #(.ITERATIONS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel8), .in_ready(rdy_b),
    .x_in(x_in), .y_in(y_in), .out_valid(ov_b), .out_ready(out_ready),
    .angle_out(ang_b), .mag_out(mag_b)
  );

  assign in_ready  = sel8 ? rdy_b : rdy_a;
  assign out_valid = sel8 ? ov_b  : ov_a;
  assign angle_out = sel8 ? ang_b : ang_a;
  assign mag_out   = sel8 ? mag_b : mag_a;

  function automatic int cur_iter();
    return sel8 ? 8 : 30;
  endfunction

  // Angle tolerance widens for short vectors (Y quantisation) and for few iterations (residual);
  // magnitude allows up to one LSB of shift truncation per micro-rotation.
  function automatic exp_t model(input int x, input int y, input int n);
    exp_t e;
    real  xr, yr, m;
    xr     = real'(x);
    yr     = real'(y);
    m      = $sqrt(xr * xr + yr * yr);
    e.zero = (x == 0) && (y == 0);
    e.mag  = m;
    if (e.zero) begin
      e.ang     = 32'd0;
      e.ang_tol = 0.0;
      e.mag_tol = 0.0;
    end else begin
      e.ang     = 32'(longint'($atan2(yr, xr) * LSB_PER_RAD));
      e.ang_tol = 256.0 + LSB_PER_RAD * ($atan($pow(2.0, real'(1 - n))) + 8.0 / m);
      e.mag_tol = 4.0 + real'(n) + m * ($pow(2.0, -20.0) + $pow(2.0, real'(6 - 2 * n)));
    end
    return e;
  endfunction

  function automatic real ang_err(input logic [31:0] a, input logic [31:0] b);
    int d;
    d = int'(a - b);
    return (d < 0) ? -real'(d) : real'(d);
  endfunction

  function automatic real mag_err(input logic [31:0] m, input real r);
    real d;
    d = real'(m) - r;
    return (d < 0.0) ? -d : d;
  endfunction

  task automatic send_vec(input int x, input int y, output bit ok);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    ok = in_ready;
    if (!ok) begin
      errors++;
      $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
    end else begin
      x_in     = x;
      y_in     = y;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      x_in     = $urandom;
      y_in     = $urandom;
      sb.push_back(model(x, y, cur_iter()));
    end
  endtask

  task automatic wait_out(output logic [31:0] a, output logic [31:0] m, output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL out_timeout: out_valid=%0b required 1 within 200 cycles", out_valid);
      lat = -1;
    end
    a = angle_out;
    m = mag_out;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(input int x, input int y, output logic [31:0] a, output logic [31:0] m,
                         output int lat, output exp_t e);
    bit ok;
    send_vec(x, y, ok);
    a = '0;
    m = '0;
    lat = -1;
    if (ok) wait_out(a, m, lat);
    if (sb.size() > 0) e = sb.pop_front();
    else e = model(x, y, cur_iter());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || angle_out !== 32'd0 || mag_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold: rdy=%0b ov=%0b ang=%h mag=%h required 1 0 0 0",
               in_ready, out_valid, angle_out, mag_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || ov_a !== 1'b0 || ov_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%0b/%0b ov=%0b/%0b required 1/1 0/0", rdy_a, rdy_b, ov_a, ov_b);
    end
  endtask

  task automatic test_axes();
    logic [31:0] a, m;
    int lat;
    exp_t e;
    int xs[2] = '{1000, 0};
    int ys[2] = '{0, 1000};
    for (int k = 0; k < 2; k++) begin
      run_vec(xs[k], ys[k], a, m, lat, e);
      checks++;
      if (ang_err(a, e.ang) > e.ang_tol) begin
        errors++;
        $display("FAIL axes_angle[%0d]: got %h required %h", k, a, e.ang);
      end
      checks++;
      if (mag_err(m, e.mag) > e.mag_tol) begin
        errors++;
        $display("FAIL axes_mag[%0d]: got %0d required %0.1f", k, m, e.mag);
      end
      checks++;
      if (lat != 31) begin
        errors++;
        $display("FAIL axes_latency[%0d]: got %0d required 31", k, lat);
      end
    end
  endtask

  task automatic test_quadrants();
    logic [31:0] a, m;
    int lat;
    exp_t e;
    int xs[3] = '{-1000, -1000, 1000};
    int ys[3] = '{-1000, 0, -1000};
    logic [31:0] nominal[3] = '{32'hA000_0000, 32'h8000_0000, 32'hE000_0000};
    for (int k = 0; k < 3; k++) begin
      run_vec(xs[k], ys[k], a, m, lat, e);
      checks++;
      if (ang_err(a, e.ang) > e.ang_tol || ang_err(a, nominal[k]) > e.ang_tol) begin
        errors++;
        $display("FAIL quad_angle[%0d]: got %h required %h", k, a, nominal[k]);
      end
      checks++;
      if (mag_err(m, e.mag) > e.mag_tol) begin
        errors++;
        $display("FAIL quad_mag[%0d]: got %0d required %0.1f", k, m, e.mag);
      end
    end
  endtask

  task automatic test_extremes();
    logic [31:0] a, m;
    int lat;
    exp_t e;
    run_vec(32'h8000_0000, 32'h8000_0000, a, m, lat, e);
    checks++;
    if (mag_err(m, e.mag) > e.mag_tol || ang_err(a, e.ang) > e.ang_tol) begin
      errors++;
      $display("FAIL extreme_min: got ang=%h mag=%0d required ang=%h mag=%0.1f", a, m, e.ang, e.mag);
    end
    run_vec(32'h8000_0000, 0, a, m, lat, e);
    checks++;
    if (mag_err(m, e.mag) > e.mag_tol || ang_err(a, 32'h8000_0000) > e.ang_tol) begin
      errors++;
      $display("FAIL extreme_neg_x: got ang=%h mag=%0d required ang=80000000 mag=%0.1f", a, m, e.mag);
    end
    run_vec(0, 0, a, m, lat, e);
    checks++;
    if (a !== 32'd0 || m !== 32'd0 || !e.zero) begin
      errors++;
      $display("FAIL zero_vector: got ang=%h mag=%h required 0 0", a, m);
    end
    checks++;
    if (lat != 31) begin
      errors++;
      $display("FAIL zero_latency: got %0d required 31", lat);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, m, a0, m0;
    int lat;
    exp_t e;
    bit ok;
    out_ready = 1'b0;
    send_vec(-12345678, 87654321, ok);
    wait_out(a0, m0, lat);
    for (int k = 0; k < 5; k++) begin
      x_in     = $urandom;
      y_in     = $urandom;
      in_valid = k[0];
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || angle_out !== a0 || mag_out !== m0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: ov=%0b ang=%h mag=%h rdy=%0b required 1 %h %h 0",
                 k, out_valid, angle_out, mag_out, in_ready, a0, m0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: ov=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
    if (sb.size() > 0) e = sb.pop_front();
    else e = model(-12345678, 87654321, 30);
    checks++;
    if (ang_err(a0, e.ang) > e.ang_tol || mag_err(m0, e.mag) > e.mag_tol) begin
      errors++;
      $display("FAIL bp_result: got ang=%h mag=%0d required ang=%h mag=%0.1f", a0, m0, e.ang, e.mag);
    end
    run_vec(555555, -777777, a, m, lat, e);
    checks++;
    if (ang_err(a, e.ang) > e.ang_tol || mag_err(m, e.mag) > e.mag_tol || lat != 31) begin
      errors++;
      $display("FAIL bp_next: got ang=%h mag=%0d lat=%0d required ang=%h mag=%0.1f lat=31",
               a, m, lat, e.ang, e.mag);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, m;
    int lat;
    int seen = 0;
    exp_t e;
    bit ok;
    send_vec(30000, -40000, ok);
    repeat (12) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || angle_out !== 32'd0 || mag_out !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: ov=%0b rdy=%0b ang=%h mag=%h required 0 1 0 0",
               out_valid, in_ready, angle_out, mag_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    if (sb.size() > 0) void'(sb.pop_back());
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_reset_discard: out_valid cycles=%0d required 0", seen);
    end
    run_vec(-300000, 400000, a, m, lat, e);
    checks++;
    if (ang_err(a, e.ang) > e.ang_tol || mag_err(m, e.mag) > e.mag_tol || lat != 31) begin
      errors++;
      $display("FAIL mid_reset_fresh: got ang=%h mag=%0d lat=%0d required ang=%h mag=%0.1f lat=31",
               a, m, lat, e.ang, e.mag);
    end
  endtask

  task automatic test_random(input bit use8);
    logic [31:0] a, m;
    int lat, x, y, n;
    exp_t e;
    sel8 = use8;
    n = cur_iter();
    for (int k = 0; k < 1000; k++) begin
      x = int'($urandom());
      y = int'($urandom());
      if (k % 8 == 0) begin
        x = x >>> 16;
        y = y >>> 20;
      end
      run_vec(x, y, a, m, lat, e);
      checks++;
      if (e.zero ? (a !== 32'd0) : (ang_err(a, e.ang) > e.ang_tol)) begin
        errors++;
        $display("FAIL random%0d_angle x=%0d y=%0d: got %h required %h", n, x, y, a, e.ang);
      end
      checks++;
      if (mag_err(m, e.mag) > e.mag_tol) begin
        errors++;
        $display("FAIL random%0d_mag x=%0d y=%0d: got %0d required %0.1f", n, x, y, m, e.mag);
      end
      checks++;
      if (lat != n + 1) begin
        errors++;
        $display("FAIL random%0d_latency: got %0d required %0d", n, lat, n + 1);
      end
    end
    sel8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_axes();
    test_quadrants();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    test_random(1'b0);
    test_random(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
